cpu_control: RTL and testbench
==============================

CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 SHALL have parameter CLEAR, default 4'd0, memory command "clear".
REQ-002 SHALL have parameter LOAD, default 4'd1, memory command "load operand".
REQ-003 SHALL have parameter HOLD, default 4'd2, memory command "hold".
REQ-004 clock  input  1  single clock; all state changes on posedge clock.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request to execute one instruction.
REQ-007 opcode  input  4  instruction code.
REQ-008 in1  input  4  first operand.
REQ-009 in2  input  4  second operand.
REQ-010 alu_result  input  4  combinational ALU output for entrada/alu_op.
REQ-011 tx  output  4  command to operand memory (CLEAR/LOAD/HOLD).
REQ-012 entrada  output  4  operand bus to datapath.
REQ-013 alu_op  output  4  operation code presented to ALU.
REQ-014 result  output  4  instruction result register.
REQ-015 busy  output  1  high while an instruction is in progress.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  illegal-opcode flag, valid with done.
REQ-018 current_state  output  4  FSM state encoding.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 States: IDLE=0, DECODE=1, LOAD_A=2, LOAD_B=3, EXEC=4, WRITE=5; codes 6-15 unreachable, SHALL go to IDLE.
REQ-021 In IDLE with start=1: latch opcode, in1, in2, go to DECODE, set busy=1; start SHALL be ignored while busy=1.
REQ-022 Latched values SHALL be used for the whole instruction; input changes after acceptance have no effect.
REQ-023 DECODE transitions: opcode 0 -> WRITE; opcode 1 -> LOAD_A; opcodes 2-7 -> LOAD_A; opcodes 8-15 -> IDLE with err=1, done=1, result unchanged.
REQ-024 LOAD_A: tx=LOAD, entrada=latched in1; next LOAD_B for opcodes 2-7, WRITE for opcode 1.
REQ-025 LOAD_B: tx=LOAD, entrada=latched in2; next EXEC.
REQ-026 EXEC: tx=HOLD, alu_op=latched opcode; sample alu_result at end of EXEC into result; next WRITE.
REQ-027 WRITE: opcode 0 -> result=0, tx=CLEAR; opcode 1 -> result=latched in1, tx=HOLD; opcodes 2-7 -> tx=HOLD; next IDLE.
REQ-028 done SHALL be high exactly the one cycle after WRITE (or after DECODE on illegal opcode); busy low in that cycle.
REQ-029 err SHALL clear on the next accepted start; unchanged otherwise.
REQ-030 tx SHALL be HOLD in IDLE and DECODE, except CLEAR after reset until first start.
REQ-031 alu_op SHALL be 4'd0 outside EXEC; entrada retains last loaded value outside LOAD_A/LOAD_B.
REQ-032 start high in the done cycle SHALL be accepted (back-to-back, no dead cycle).
REQ-033 ALU-op latency: start at cycle N -> done at N+6; opcode 1: N+4; opcode 0: N+3.

Reset
REQ-034 reset_n=0 at a clock edge SHALL force IDLE, tx=CLEAR, entrada=0, alu_op=0, result=0, busy=0, done=0, err=0, current_state=0.
REQ-035 Reset mid-instruction SHALL abort it with no done pulse; reset overrides start.

Verification
REQ-036 Reset, then start, opcode=2, in1=3, in2=5, alu_result model a+b -> entrada 3 then 5 with tx=LOAD, result=8, done at N+6.
REQ-037 opcode=1, in1=9 -> LOAD_A only, result=9, done at N+4; opcode=0 -> result=0, tx=CLEAR in WRITE, done at N+3.
REQ-038 opcode=12 -> err=1, done=1 at N+2, result unchanged; next legal start clears err.
REQ-039 Change in1/in2/opcode and pulse start during LOAD_B -> ignored, result from original operands.
REQ-040 Assert reset_n=0 in EXEC -> next cycle IDLE, all outputs at reset values, no done; start in done cycle -> immediate DECODE.

Source files
------------

// File: rtl/cpu_control.sv
// Instruction sequencer for a small datapath: steps operands onto the bus, drives the ALU
// opcode and captures the result. All outputs come straight from registers.
module cpu_control #(
    parameter logic [3:0] CLEAR = 4'd0,
    parameter logic [3:0] LOAD  = 4'd1,
    parameter logic [3:0] HOLD  = 4'd2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] alu_result,
    output logic [3:0] tx,
    output logic [3:0] entrada,
    output logic [3:0] alu_op,
    output logic [3:0] result,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] current_state
);

    // state  | meaning
    // IDLE   | waiting for start; done/err reflect the previous instruction
    // DECODE | classify latched opcode
    // LOAD_A | first operand on entrada, tx=LOAD
    // LOAD_B | second operand on entrada, tx=LOAD
    // EXEC   | alu_op driven, alu_result captured at the end of the cycle
    // WRITE  | result final, completion pulse follows
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DECODE = 4'd1,
        S_LOAD_A = 4'd2,
        S_LOAD_B = 4'd3,
        S_EXEC   = 4'd4,
        S_WRITE  = 4'd5
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] op_q, a_q, b_q;
    logic [3:0] op_nxt, a_nxt, b_nxt;
    logic       started_q, started_nxt;
    logic [3:0] tx_nxt, entrada_nxt, alu_op_nxt, result_nxt;
    logic       busy_nxt, done_nxt, err_nxt;

    always_comb begin
        state_nxt   = S_IDLE;
        op_nxt      = op_q;
        a_nxt       = a_q;
        b_nxt       = b_q;
        started_nxt = started_q;
        result_nxt  = result;
        err_nxt     = err;
        done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_DECODE;
                    op_nxt      = opcode;
                    a_nxt       = in1;
                    b_nxt       = in2;
                    err_nxt     = 1'b0;
                    started_nxt = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_q == 4'd0) begin
                    state_nxt  = S_WRITE;
                    result_nxt = 4'd0;
                end else if (op_q[3]) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (op_q == 4'd1) begin
                    state_nxt  = S_WRITE;
                    result_nxt = a_q;
                end else begin
                    state_nxt = S_LOAD_B;
                end
            end
            S_LOAD_B: state_nxt = S_EXEC;
            S_EXEC: begin
                state_nxt  = S_WRITE;
                result_nxt = alu_result;
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        busy_nxt    = (state_nxt != S_IDLE);
        alu_op_nxt  = (state_nxt == S_EXEC) ? op_q : 4'd0;
        tx_nxt      = HOLD;
        entrada_nxt = entrada;
        case (state_nxt)
            S_IDLE:   tx_nxt = started_nxt ? HOLD : CLEAR;
            S_LOAD_A: begin
                tx_nxt      = LOAD;
                entrada_nxt = a_q;
            end
            S_LOAD_B: begin
                tx_nxt      = LOAD;
                entrada_nxt = b_q;
            end
            S_WRITE:  tx_nxt = (op_q == 4'd0) ? CLEAR : HOLD;
            default:  tx_nxt = HOLD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            op_q      <= 4'd0;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            started_q <= 1'b0;
            tx        <= CLEAR;
            entrada   <= 4'd0;
            alu_op    <= 4'd0;
            result    <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            started_q <= started_nxt;
            tx        <= tx_nxt;
            entrada   <= entrada_nxt;
            alu_op    <= alu_op_nxt;
            result    <= result_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    assign current_state = state;

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: an instruction-level schedule model predicts every output each cycle,
// and directed scenarios pin key values by hand.
module tb_cpu_control;

    localparam logic [3:0] CLEAR = 4'd0;
    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] HOLD  = 4'd2;

    logic       clock = 1'b0;
    logic       reset_n, start;
    logic [3:0] opcode, in1, in2, alu_result;
    logic [3:0] tx, entrada, alu_op, result, current_state;
    logic       busy, done, err;

    int total = 0;
    int bad   = 0;

    cpu_control dut (
        .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
        .in1(in1), .in2(in2), .alu_result(alu_result), .tx(tx), .entrada(entrada),
        .alu_op(alu_op), .result(result), .busy(busy), .done(done), .err(err),
        .current_state(current_state)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a;
            default: return 4'd0;
        endcase
    endfunction

    // Operand memory + ALU seen by the DUT: each LOAD shifts entrada in.
    logic [3:0] mem0 = 4'd0, mem1 = 4'd0;
    always @(posedge clock) if (tx == LOAD) begin
        mem0 <= mem1;
        mem1 <= entrada;
    end
    assign alu_result = alu_f(alu_op, mem0, mem1);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] tx, entrada, alu_op, result;
        logic       busy, done, err;
        logic [3:0] cs;
    } rec_t;

    function automatic rec_t mk(input logic [3:0] t, input logic [3:0] e, input logic [3:0] ao,
                                input logic [3:0] r, input logic b, input logic d, input logic er,
                                input logic [3:0] cs);
        rec_t x;
        x.tx = t; x.entrada = e; x.alu_op = ao; x.result = r;
        x.busy = b; x.done = d; x.err = er; x.cs = cs;
        return x;
    endfunction

    rec_t       exp_q[$];
    rec_t       cur;
    bit         model_valid = 0;
    logic [3:0] m_tx_idle, m_ent, m_res;
    logic       m_err;

    // Expand one accepted instruction into its per-cycle expected outputs.
    task automatic build(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ent = m_ent;
        logic [3:0] res = m_res;
        m_err     = 1'b0;
        m_tx_idle = HOLD;
        exp_q.push_back(mk(HOLD, ent, 0, res, 1, 0, 0, 1));
        if (op == 4'd0) begin
            res = 4'd0;
            exp_q.push_back(mk(CLEAR, ent, 0, res, 1, 0, 0, 5));
            exp_q.push_back(mk(HOLD, ent, 0, res, 0, 1, 0, 0));
        end else if (op >= 4'd8) begin
            m_err = 1'b1;
            exp_q.push_back(mk(HOLD, ent, 0, res, 0, 1, 1, 0));
        end else if (op == 4'd1) begin
            ent = a;
            exp_q.push_back(mk(LOAD, ent, 0, res, 1, 0, 0, 2));
            res = a;
            exp_q.push_back(mk(HOLD, ent, 0, res, 1, 0, 0, 5));
            exp_q.push_back(mk(HOLD, ent, 0, res, 0, 1, 0, 0));
        end else begin
            exp_q.push_back(mk(LOAD, a, 0, res, 1, 0, 0, 2));
            ent = b;
            exp_q.push_back(mk(LOAD, ent, 0, res, 1, 0, 0, 3));
            exp_q.push_back(mk(HOLD, ent, op, res, 1, 0, 0, 4));
            res = alu_f(op, a, b);
            exp_q.push_back(mk(HOLD, ent, 0, res, 1, 0, 0, 5));
            exp_q.push_back(mk(HOLD, ent, 0, res, 0, 1, 0, 0));
        end
        m_ent = ent;
        m_res = res;
    endtask

    always @(posedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            m_tx_idle = CLEAR; m_ent = 0; m_res = 0; m_err = 0;
            cur = mk(CLEAR, 0, 0, 0, 0, 0, 0, 0);
            model_valid = 1;
        end else if (model_valid) begin
            if (!cur.busy && start) build(opcode, in1, in2);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = mk(m_tx_idle, m_ent, 0, m_res, 0, 0, m_err, 0);
        end
    end

    always @(negedge clock) if (model_valid) begin
        chk("tx", tx, cur.tx);
        chk("entrada", entrada, cur.entrada);
        chk("alu_op", alu_op, cur.alu_op);
        chk("result", result, cur.result);
        chk("busy", busy, cur.busy);
        chk("done", done, cur.done);
        chk("err", err, cur.err);
        chk("current_state", current_state, cur.cs);
    end

    // Drives start for one cycle; returns at the negedge of cycle N+1.
    task automatic launch(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clock);
        opcode = op; in1 = a; in2 = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Stays at the negedge of the done cycle on return.
    task automatic wait_done(input int cyc_now, input int exp_lat, input string nm);
        int c = cyc_now;
        while (!done && c < 20) begin
            @(negedge clock);
            c++;
        end
        chk(nm, c, exp_lat);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; opcode = 0; in1 = 0; in2 = 0;
        repeat (3) @(negedge clock);
        chk("rst_tx", tx, CLEAR);
        chk("rst_state", current_state, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_tx_clear", tx, CLEAR);

        // add 3+5
        launch(4'd2, 4'd3, 4'd5);
        chk("add_decode", current_state, 1);
        @(negedge clock);
        chk("add_ent_a", entrada, 3);
        chk("add_tx_load", tx, LOAD);
        @(negedge clock);
        chk("add_ent_b", entrada, 5);
        wait_done(3, 6, "add_latency");
        chk("add_result", result, 8);
        chk("add_busy_low", busy, 0);

        // clear
        launch(4'd0, 4'd7, 4'd7);
        @(negedge clock);
        chk("clr_tx_write", tx, CLEAR);
        wait_done(2, 3, "clr_latency");
        chk("clr_result", result, 0);

        // load operand
        launch(4'd1, 4'd9, 4'd2);
        wait_done(1, 4, "ld_latency");
        chk("ld_result", result, 9);

        // illegal opcode
        launch(4'd12, 4'd1, 4'd1);
        wait_done(1, 2, "ill_latency");
        chk("ill_err", err, 1);
        chk("ill_result", result, 9);

        // next legal start clears err
        launch(4'd3, 4'd7, 4'd2);
        chk("err_cleared", err, 0);
        wait_done(1, 6, "sub_latency");
        chk("sub_result", result, 5);

        // inputs disturbed during LOAD_B
        launch(4'd4, 4'd12, 4'd10);
        @(negedge clock);
        @(negedge clock);
        opcode = 4'd7; in1 = 4'd1; in2 = 4'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(4, 6, "and_latency");
        chk("and_result", result, 8);

        // back-to-back: start held in the done cycle
        launch(4'd5, 4'd12, 4'd3);
        wait_done(1, 6, "or_latency");
        chk("or_result", result, 15);
        opcode = 4'd6; in1 = 4'd9; in2 = 4'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("b2b_decode", current_state, 1);
        wait_done(1, 6, "xor_latency");
        chk("xor_result", result, 12);

        // reset in EXEC
        launch(4'd7, 4'd4, 4'd6);
        repeat (3) @(negedge clock);
        chk("exec_state", current_state, 4);
        reset_n = 1'b0;
        @(negedge clock);
        chk("abort_state", current_state, 0);
        chk("abort_result", result, 0);
        chk("abort_done", done, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("abort_no_done", done, 0);
        chk("abort_tx_clear", tx, CLEAR);

        launch(4'd2, 4'd15, 4'd1);
        wait_done(1, 6, "wrap_latency");
        chk("wrap_result", result, 0);
        @(negedge clock);
        chk("idle_tx_hold", tx, HOLD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
